// File: rtl/fp16_mult_arbiter.sv
// -----------------------------------------------------------------------------
// fp16_mult_arbiter
//
// A round-robin arbiter and a two-stage issue pipeline that let NUM_REQ
// requesters share one combinational FP16 multiplier (float_mult_16bit).
//   S1 : issue register. Holds the granted operands, id and tag, and drives
//        the multiplier inputs.
//   S2 : response register. Holds the product, id, tag and flags.
// Both stages stall under response backpressure, so with rsp_ready held low
// at most two requests are in flight.
//
// Optional feature macro: FP16_MULT_ARB_FLAGS_EN
//   defined   : rsp_flags = {nan, inf}, decoded from the product and
//               registered in S2.
//   undefined : rsp_flags is tied to 2'b00. The port list is the same in
//               both builds.
//
// Ports
//   CLK, RST      clock; synchronous active-high reset
//   req_valid     [NUM_REQ]       requester i presents an operand pair
//   req_ready     [NUM_REQ]       one-hot grant (accept = valid & ready)
//   req_float1/2  [NUM_REQ*16]    operands; requester i is at [16i+15:16i]
//   req_tag       [NUM_REQ*TAG_W] opaque per-request tag
//   rsp_valid     response register holds a result
//   rsp_ready     consumer accepts the response
//   rsp_id        index of the requester that issued the result
//   rsp_tag       tag captured at accept
//   rsp_product   multiplier result
//   rsp_flags     {nan, inf}
//   busy          either pipeline stage is valid
// -----------------------------------------------------------------------------

// Combinational half-precision multiplier.
//   NaN input, or infinity times zero -> 16'hFFFF
//   infinity times a finite operand   -> signed infinity
//   subnormal inputs are flushed to zero
//   exponent overflow gives infinity, underflow gives zero
//   the mantissa is truncated (no rounding)
module float_mult_16bit (
  input  logic [15:0] i_float1,
  input  logic [15:0] i_float2,
  output logic [15:0] o_product
);

  logic        w_sign;
  logic [4:0]  w_exp1, w_exp2;
  logic [9:0]  w_man1, w_man2;
  logic        w_nan1, w_nan2, w_inf1, w_inf2, w_zero1, w_zero2;
  logic [21:0] w_man_prod;
  logic        w_norm;
  logic [6:0]  w_exp_sum;
  logic [9:0]  w_man_res;

  assign w_sign  = i_float1[15] ^ i_float2[15];
  assign w_exp1  = i_float1[14:10];
  assign w_exp2  = i_float2[14:10];
  assign w_man1  = i_float1[9:0];
  assign w_man2  = i_float2[9:0];
  assign w_nan1  = (w_exp1 == 5'h1F) && (w_man1 != 10'd0);
  assign w_nan2  = (w_exp2 == 5'h1F) && (w_man2 != 10'd0);
  assign w_inf1  = (w_exp1 == 5'h1F) && (w_man1 == 10'd0);
  assign w_inf2  = (w_exp2 == 5'h1F) && (w_man2 == 10'd0);
  assign w_zero1 = (w_exp1 == 5'd0);
  assign w_zero2 = (w_exp2 == 5'd0);

  // The product of the two 1.m significands lies in [1,4). Bit 21 set means
  // the product is at least 2, so shift right by one and bump the exponent.
  assign w_man_prod = 22'({1'b1, w_man1}) * 22'({1'b1, w_man2});
  assign w_norm     = w_man_prod[21];
  assign w_man_res  = w_norm ? w_man_prod[20:11] : w_man_prod[19:10];

  // Biased sum e1 + e2 + norm. The result exponent is this sum minus 15,
  // so a sum of 15 or less underflows and a sum of 46 or more overflows.
  assign w_exp_sum  = 7'(w_exp1) + 7'(w_exp2) + 7'(w_norm);

  // NOTE: every branch of always_comb assigns the output (default first), so no latch is inferred.
  always_comb begin
    o_product = {w_sign, 5'(w_exp_sum - 7'd15), w_man_res};
    if (w_nan1 || w_nan2 || (w_inf1 && w_zero2) || (w_inf2 && w_zero1)) begin
      o_product = 16'hFFFF;
    end else if (w_inf1 || w_inf2) begin
      o_product = {w_sign, 5'h1F, 10'd0};
    end else if (w_zero1 || w_zero2) begin
      o_product = {w_sign, 15'd0};
    end else if (w_exp_sum >= 7'd46) begin
      o_product = {w_sign, 5'h1F, 10'd0};
    end else if (w_exp_sum <= 7'd15) begin
      o_product = {w_sign, 15'd0};
    end
  end

endmodule

module fp16_mult_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int TAG_W        = 4,
  localparam int HALF_FLOAT_W = 16,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*HALF_FLOAT_W-1:0] req_float1,
  input  logic [NUM_REQ*HALF_FLOAT_W-1:0] req_float2,
  input  logic [NUM_REQ*TAG_W-1:0]       req_tag,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [TAG_W-1:0]               rsp_tag,
  output logic [HALF_FLOAT_W-1:0]        rsp_product,
  output logic [1:0]                     rsp_flags,
  output logic                           busy
);

  // (p + k) modulo NUM_REQ, for p < NUM_REQ and k <= NUM_REQ.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Pipeline state
  logic                    r_s1_valid;
  logic [HALF_FLOAT_W-1:0] r_s1_float1, r_s1_float2;
  logic [ID_W-1:0]         r_s1_id;
  logic [TAG_W-1:0]        r_s1_tag;
  logic [ID_W-1:0]         r_rr_ptr;
  logic                    r_rsp_valid;
  logic [ID_W-1:0]         r_rsp_id;
  logic [TAG_W-1:0]        r_rsp_tag;
  logic [HALF_FLOAT_W-1:0] r_rsp_product;

  logic                    w_s2_open, w_s1_open;
  logic                    w_gnt_found;
  logic [ID_W-1:0]         w_gnt_idx;
  logic                    w_accept;
  logic [HALF_FLOAT_W-1:0] w_product;

  // Stall chain. S2 can load when it is empty or being drained; S1 can load
  // when it is empty or can move into S2 this cycle.
  assign w_s2_open = !r_rsp_valid || rsp_ready;
  assign w_s1_open = !r_s1_valid  || w_s2_open;

  // Round-robin search starting at r_rr_ptr. The grant depends only on
  // req_valid and the pointer, never on operand values.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_gnt_found && req_valid[wrap_add(r_rr_ptr, k)]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = wrap_add(r_rr_ptr, k);
      end
    end
  end

  // RST gates the grant so that req_ready reads 0 while reset is held.
  assign w_accept  = w_gnt_found && w_s1_open && !RST;
  assign req_ready = w_accept ? (NUM_REQ'(1) << w_gnt_idx) : '0;

  float_mult_16bit u_mult (
    .i_float1  (r_s1_float1),
    .i_float2  (r_s1_float2),
    .o_product (w_product)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values and the stages move in lockstep.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1_valid    <= 1'b0;
      r_s1_float1   <= '0;
      r_s1_float2   <= '0;
      r_s1_id       <= '0;
      r_s1_tag      <= '0;
      r_rr_ptr      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_tag     <= '0;
      r_rsp_product <= '0;
    end else begin
      // S1: a new accept may overlap with the S1->S2 move, giving one
      // result per cycle.
      if (w_accept) begin
        r_s1_valid  <= 1'b1;
        r_s1_float1 <= req_float1[w_gnt_idx*HALF_FLOAT_W +: HALF_FLOAT_W];
        r_s1_float2 <= req_float2[w_gnt_idx*HALF_FLOAT_W +: HALF_FLOAT_W];
        r_s1_id     <= w_gnt_idx;
        r_s1_tag    <= req_tag[w_gnt_idx*TAG_W +: TAG_W];
        r_rr_ptr    <= wrap_add(w_gnt_idx, 1);
      end else if (w_s2_open) begin
        r_s1_valid  <= 1'b0;
      end

      // S2 holds while the consumer stalls, which keeps the response stable.
      if (w_s2_open) begin
        r_rsp_valid   <= r_s1_valid;
        r_rsp_id      <= r_s1_id;
        r_rsp_tag     <= r_s1_tag;
        r_rsp_product <= w_product;
      end
    end
  end

`ifdef FP16_MULT_ARB_FLAGS_EN
  logic [1:0] r_rsp_flags;
  logic       w_exp_ones;
  logic [1:0] w_flags;

  assign w_exp_ones = &w_product[14:10];
  assign w_flags    = {w_exp_ones && (w_product[9:0] != 10'd0),
                       w_exp_ones && (w_product[9:0] == 10'd0)};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rsp_flags <= 2'b00;
    end else if (w_s2_open) begin
      r_rsp_flags <= w_flags;
    end
  end

  assign rsp_flags = r_rsp_flags;
`else
  assign rsp_flags = 2'b00;
`endif

  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_tag     = r_rsp_tag;
  assign rsp_product = r_rsp_product;
  assign busy        = r_s1_valid || r_rsp_valid;

endmodule

// File: tb/tb_fp16_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp16_mult_arbiter
//
// Self-checking bench for fp16_mult_arbiter (NUM_REQ = 4, TAG_W = 4).
// Expected products are hand-computed FP16 constants. Every accepted request
// pushes {id, tag, product, flags} onto a scoreboard. Every response
// handshake pops the queue and compares the popped entry with the response.
// -----------------------------------------------------------------------------
module tb_fp16_mult_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 4;

  typedef struct packed {
    logic [1:0]  id;
    logic [3:0]  tag;
    logic [15:0] prod;
    logic [1:0]  flags;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*16-1:0]   req_float1;
  logic [NUM_REQ*16-1:0]   req_float2;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [1:0]              rsp_id;
  logic [TAG_W-1:0]        rsp_tag;
  logic [15:0]             rsp_product;
  logic [1:0]              rsp_flags;
  logic                    busy;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  int   grant_log[$];
  int   rsp_log[$];
  logic [15:0] exp_prod [NUM_REQ];

  fp16_mult_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .CLK         (clk),
    .RST         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_float1  (req_float1),
    .req_float2  (req_float2),
    .req_tag     (req_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_tag     (rsp_tag),
    .rsp_product (rsp_product),
    .rsp_flags   (rsp_flags),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_flags(input logic [15:0] p);
`ifdef FP16_MULT_ARB_FLAGS_EN
    return {(&p[14:10]) && (p[9:0] != 10'd0), (&p[14:10]) && (p[9:0] == 10'd0)};
`else
    return 2'b00;
`endif
  endfunction

  // Monitor on the falling edge. Inputs change only just after rising edges,
  // so a handshake seen here is the one the next rising edge will take.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rsp: got id=%0d tag=%0h prod=%04h, scoreboard empty",
                   rsp_id, rsp_tag, rsp_product);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({rsp_id, rsp_tag, rsp_product, rsp_flags} !== e) begin
            bad++;
            $display("FAIL rsp_compare: got id=%0d tag=%0h prod=%04h flags=%b, want id=%0d tag=%0h prod=%04h flags=%b",
                     rsp_id, rsp_tag, rsp_product, rsp_flags, e.id, e.tag, e.prod, e.flags);
          end
        end
        rsp_log.push_back(int'(rsp_id));
      end
      total++;
      if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) begin
        bad++;
        $display("FAIL grant_onehot: req_ready=%b req_valid=%b", req_ready, req_valid);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back({2'(i), req_tag[i*TAG_W +: TAG_W], exp_prod[i], exp_flags(exp_prod[i])});
          grant_log.push_back(i);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps one cycle and drops the valid of any requester that was accepted.
  task automatic step_req();
    logic [NUM_REQ-1:0] acc;
    #1;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] tag, input logic [15:0] prod);
    req_float1[i*16 +: 16]   = a;
    req_float2[i*16 +: 16]   = b;
    req_tag[i*TAG_W +: TAG_W] = tag;
    exp_prod[i]              = prod;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    while ((sb.size() != 0 || busy) && n < 100) begin
      step();
      n++;
    end
    total++;
    if (sb.size() != 0 || busy) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d busy=%b, want 0 and 0", sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'h3C00, 16'h3C00, 4'(i), 16'h3C00);
    req_valid = '1;
    repeat (3) step();
    total++;
    if (req_ready !== 4'b0000) begin
      bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    end
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_valid_busy: got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
    total++;
    if ({rsp_id, rsp_tag, rsp_product, rsp_flags} !== 24'd0) begin
      bad++; $display("FAIL reset_rsp_fields: got id=%0d tag=%0h prod=%04h flags=%b want all 0",
                      rsp_id, rsp_tag, rsp_product, rsp_flags);
    end
    req_valid = '0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    rsp_ready = 1'b1;
    set_req(0, 16'h3C00, 16'h4000, 4'd5, 16'h4000);
    req_valid = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL basic_grant: got %b want 0001", req_ready);
    end
    step();
    req_valid = '0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL basic_latency_s1: got rsp_valid=%b busy=%b want 0 1", rsp_valid, busy);
    end
    step();
    total++;
    if (rsp_valid !== 1'b1 || rsp_product !== 16'h4000 || rsp_id !== 2'd0 ||
        rsp_tag !== 4'd5 || rsp_flags !== 2'b00) begin
      bad++; $display("FAIL basic_result: got v=%b prod=%04h id=%0d tag=%0h flags=%b want 1 4000 0 5 00",
                      rsp_valid, rsp_product, rsp_id, rsp_tag, rsp_flags);
    end
    wait_drain();
  endtask

  task automatic test_round_robin();
    apply_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'h4000, 16'h4200, 4'(8 + i), 16'h4600);
    grant_log.delete();
    rsp_log.delete();
    req_valid = '1;
    repeat (8) step();
    req_valid = '0;
    wait_drain();
    total++;
    if (grant_log.size() != 8 || rsp_log.size() != 8) begin
      bad++; $display("FAIL rr_count: got grants=%0d rsps=%0d want 8 8", grant_log.size(), rsp_log.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        total++;
        if (grant_log[k] != k % 4 || rsp_log[k] != k % 4) begin
          bad++; $display("FAIL rr_order[%0d]: got grant=%0d rsp_id=%0d want %0d", k, grant_log[k], rsp_log[k], k % 4);
        end
      end
    end
  endtask

  task automatic test_back_to_back_backpressure();
    exp_t held;
    rsp_ready = 1'b0;
    set_req(1, 16'h4200, 16'h4200, 4'd1, 16'h4880);
    set_req(2, 16'hC000, 16'h3800, 4'd2, 16'hBC00);
    set_req(3, 16'h3E00, 16'h3E00, 4'd3, 16'h4080);
    grant_log.delete();
    rsp_log.delete();
    req_valid = 4'b0110;
    step_req();
    step_req();
    #1;
    total++;
    if (grant_log.size() != 2 || req_ready !== 4'b0000 || rsp_valid !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL bp_full: got grants=%0d req_ready=%b rsp_valid=%b busy=%b want 2 0000 1 1",
                      grant_log.size(), req_ready, rsp_valid, busy);
    end
    held = {2'd1, 4'd1, 16'h4880, exp_flags(16'h4880)};
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if ({rsp_id, rsp_tag, rsp_product, rsp_flags} !== held || rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
        bad++; $display("FAIL bp_stable[%0d]: got v=%b id=%0d tag=%0h prod=%04h req_ready=%b want 1 1 1 4880 0000",
                        c, rsp_valid, rsp_id, rsp_tag, rsp_product, req_ready);
      end
    end
    req_valid[3] = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin
      bad++; $display("FAIL bp_still_blocked: got %b want 0000", req_ready);
    end
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b1000) begin
      bad++; $display("FAIL bp_release_same_cycle: got %b want 1000", req_ready);
    end
    step_req();
    wait_drain();
    total++;
    if (rsp_log.size() != 3 || rsp_log[0] != 1 || rsp_log[1] != 2 || rsp_log[2] != 3) begin
      bad++; $display("FAIL bp_rsp_order: got %0d responses (first ids %0d,%0d) want ids 1,2,3",
                      rsp_log.size(), (rsp_log.size() > 0) ? rsp_log[0] : -1, (rsp_log.size() > 1) ? rsp_log[1] : -1);
    end
  endtask

  task automatic test_special();
    rsp_ready = 1'b1;
    rsp_log.delete();
    set_req(0, 16'h7C00, 16'h3C00, 4'd6, 16'h7C00);
    req_valid = 4'b0001;
    step_req();
    set_req(0, 16'h7E00, 16'h3C00, 4'd7, 16'hFFFF);
    req_valid = 4'b0001;
    step_req();
    wait_drain();
    total++;
    if (rsp_log.size() != 2) begin
      bad++; $display("FAIL special_count: got %0d responses want 2", rsp_log.size());
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'h3E00, 16'h3E00, 4'(i), 16'h4080);
    req_valid = '1;
    step();
    step();
    #1;
    total++;
    if (rsp_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 4'b0000) begin
      bad++; $display("FAIL rstmid_full: got rsp_valid=%b busy=%b req_ready=%b want 1 1 0000",
                      rsp_valid, busy, req_ready);
    end
    rst = 1'b1;
    step();
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      bad++; $display("FAIL rstmid_cleared: got rsp_valid=%b busy=%b req_ready=%b want 0 0 0000",
                      rsp_valid, busy, req_ready);
    end
    sb.delete();
    grant_log.delete();
    rsp_log.delete();
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL rstmid_first_grant: got %b want 0001", req_ready);
    end
    rsp_ready = 1'b1;
    step();
    req_valid = '0;
    wait_drain();
    total++;
    if (grant_log.size() != 1 || grant_log[0] != 0 || rsp_log.size() != 1) begin
      bad++; $display("FAIL rstmid_after: got grants=%0d rsps=%0d want 1 1 (requester 0)",
                      grant_log.size(), rsp_log.size());
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    rsp_ready = 1'b1;
    set_req(3, 16'h4000, 16'h4000, 4'd3, 16'h4400);
    set_req(0, 16'h3C00, 16'h3C00, 4'd0, 16'h3C00);
    req_valid = 4'b1000;
    step_req();
    grant_log.delete();
    req_valid = 4'b1001;
    step_req();
    step_req();
    wait_drain();
    total++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 3) begin
      bad++; $display("FAIL wrap_order: got %0d grants (first %0d) want 0 then 3",
                      grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    rsp_ready  = 1'b0;
    req_float1 = '0;
    req_float2 = '0;
    req_tag    = '0;
    for (int i = 0; i < NUM_REQ; i++) exp_prod[i] = 16'h0000;
    step();
    test_reset();
    test_basic();
    test_round_robin();
    test_back_to_back_backpressure();
    test_special();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
